bitserial_gate_seq: RTL and testbench

Bit-serial operand sequencer that sits directly upstream of the single-bit NAND/NOR gate stage and also collects its results. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and presents one bit pair per cycle to the gate stage on `gate_x`/`gate_y`. It captures the stage's `gate_nand`/`gate_nor` responses in the same cycle and returns full WIDTH-bit NAND and NOR result words over a second valid/ready handshake.

---
 rtl/bitserial_gate_seq.sv | 154 +++++++++++++++
 tb/tb_bitserial_gate_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bitserial_gate_seq.sv
// bitserial_gate_seq
//   Bit-serial operand sequencer for an external single-bit NAND/NOR gate
//   stage. Accepts an X/Y operand pair and presents the bits to the gate
//   stage LSB first, one pair per cycle. It collects the gate responses and
//   returns full-width NAND and NOR words.
//
// Optional feature macro: SEQ_SELFCHECK_EN
//   When defined, every gate response is checked against the expected logic
//   function, and a mismatch sets the sticky err flag. When undefined, err
//   is tied to 0.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake, in_x/in_y WIDTH-bit operands
//   gate_x/gate_y         registered bit pair driven to the gate stage
//   gate_nand/gate_nor    combinational responses from the gate stage
//   out_valid/out_ready   result handshake, out_nand/out_nor result words
//   busy                  high whenever not IDLE
//   err                   sticky self-check error
module bitserial_gate_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             gate_x,
  output logic             gate_y,
  input  logic             gate_nand,
  input  logic             gate_nor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_nand,
  output logic [WIDTH-1:0] out_nor,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] xsh_q, xsh_d, ysh_q, ysh_d;
  logic [WIDTH-1:0] nand_q, nand_d, nor_q, nor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gx_q, gx_d, gy_q, gy_d;
  logic             accept, last;

  assign accept = in_valid & in_ready;
  // The final sample edge is the one where the count reaches WIDTH-1.
  assign last   = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath next state
  always_comb begin
    xsh_d  = xsh_q;
    ysh_d  = ysh_q;
    nand_d = nand_q;
    nor_d  = nor_q;
    cnt_d  = cnt_q;
    gx_d   = gx_q;
    gy_d   = gy_q;
    if (accept) begin
      xsh_d = in_x;
      ysh_d = in_y;
      cnt_d = '0;
      // gate bits are registered, so bit 0 is presented right after accept
      gx_d  = in_x[0];
      gy_d  = in_y[0];
    end else if (state_q == SHIFT) begin
      // responses shift in at the MSB so bit i lands in position i after
      // WIDTH samples
      nand_d = (nand_q >> 1) | (WIDTH'(gate_nand) << (WIDTH - 1));
      nor_d  = (nor_q  >> 1) | (WIDTH'(gate_nor)  << (WIDTH - 1));
      xsh_d  = xsh_q >> 1;
      ysh_d  = ysh_q >> 1;
      cnt_d  = cnt_q + CW'(1);
      gx_d   = ~last & xsh_d[0];
      gy_d   = ~last & ysh_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xsh_q  <= '0;
      ysh_q  <= '0;
      nand_q <= '0;
      nor_q  <= '0;
      cnt_q  <= '0;
      gx_q   <= 1'b0;
      gy_q   <= 1'b0;
    end else begin
      xsh_q  <= xsh_d;
      ysh_q  <= ysh_d;
      nand_q <= nand_d;
      nor_q  <= nor_d;
      cnt_q  <= cnt_d;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
    end
  end

  assign gate_x   = gx_q;
  assign gate_y   = gy_q;
  assign out_nand = nand_q;
  assign out_nor  = nor_q;

`ifdef SEQ_SELFCHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == SHIFT) &&
        ((gate_nand != ~(gx_q & gy_q)) || (gate_nor != ~(gx_q | gy_q))))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bitserial_gate_seq.sv
module tb_bitserial_gate_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0, in_y = '0;
  logic         gate_x, gate_y, gate_nand, gate_nor;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_nand, out_nor;
  logic         busy, err;
  logic         stub_nand0 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate stage model; the stub forces a wrong NAND response on demand.
  assign gate_nand = stub_nand0 ? 1'b0 : ~(gate_x & gate_y);
  assign gate_nor  = ~(gate_x | gate_y);

  bitserial_gate_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .gate_x(gate_x), .gate_y(gate_y), .gate_nand(gate_nand), .gate_nor(gate_nor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_nand(out_nand), .out_nor(out_nor), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},  {31'b0, in_ready},  32'd1);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".busy"},      {31'b0, busy},      32'd0);
    chk({tag, ".gate"},      {30'b0, gate_x, gate_y}, 32'd0);
    chk({tag, ".results"},   {16'b0, out_nand, out_nor}, 32'd0);
  endtask

  // One full operation. bp = cycles of backpressure after out_valid rises;
  // early = out_ready already high when out_valid rises.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int bp, input bit early, input logic exp_err);
    logic [W-1:0] exp_nand, exp_nor;
    int n;
    bit gate_ok;
    exp_nand = ~(x & y);
    exp_nor  = ~(x | y);
    chk("op.in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_x = x; in_y = y;
    out_ready = early;
    tick();
    in_valid = 1'b0;
    chk("op.busy_after_accept", {31'b0, busy}, 32'd1);
    n = 0;
    gate_ok = 1'b1;
    while (!out_valid && n < 4 * W) begin
      if (n < W && (gate_x !== x[n] || gate_y !== y[n])) gate_ok = 1'b0;
      if (in_ready !== 1'b0) gate_ok = 1'b0;
      tick();
      n++;
    end
    chk("op.gate_bits_lsb_first", {31'b0, gate_ok}, 32'd1);
    chk("op.latency", n, W);
    chk("op.out_nand", {24'b0, out_nand}, {24'b0, exp_nand});
    chk("op.out_nor",  {24'b0, out_nor},  {24'b0, exp_nor});
    chk("op.gate_zero_done", {30'b0, gate_x, gate_y}, 32'd0);
    chk("op.err", {31'b0, err}, {31'b0, exp_err});
    if (!early) begin
      // Offer a new operand pair during backpressure; it must be ignored.
      in_valid = 1'b1; in_x = ~x; in_y = y ^ 8'h5A;
      for (int i = 0; i < bp; i++) begin
        tick();
        chk("bp.hold", {14'b0, out_valid, in_ready, out_nand, out_nor},
            {14'b0, 1'b1, 1'b0, exp_nand, exp_nor});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    chk("op.handshake_idle", {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    bit clean;
    logic [W-1:0] rx, ry;

    #12;
    chk_reset_vals("reset_asserted");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("reset_idle");
    chk("reset.err", {31'b0, err}, 32'd0);

    // Basic op
    run_op(8'hF0, 8'hCC, 0, 1'b0, 1'b0);
    // Backpressure
    run_op(8'hA5, 8'h3C, 5, 1'b0, 1'b0);
    // Back-to-back with early out_ready
    run_op(8'hFF, 8'h00, 0, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 0, 1'b0, 1'b0);

    // Reset during SHIFT bit 3
    in_valid = 1'b1; in_x = 8'h96; in_y = 8'h0F;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid.bit3_presented", {30'b0, gate_x, gate_y}, {30'b0, 1'b0, 1'b1});
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    chk("mid.err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clean = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) clean = 1'b0;
    end
    chk("mid.no_out_valid", {31'b0, clean}, 32'd1);
    run_op(8'h96, 8'h0F, 1, 1'b0, 1'b0);

    // Randomized operations
    for (int k = 0; k < 24; k++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      run_op(rx, ry, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0);
    end

`ifdef SEQ_SELFCHECK_EN
    // Faulty gate stage: NAND stuck at 0 with zero operands
    stub_nand0 = 1'b1;
    in_valid = 1'b1; in_x = 8'h00; in_y = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("sc.err_before_sample", {31'b0, err}, 32'd0);
    tick();
    chk("sc.err_first_sample", {31'b0, err}, 32'd1);
    for (int i = 0; i < W + 2 && !out_valid; i++) tick();
    chk("sc.err_done", {32'b0, err, out_valid}, {32'b0, 2'b11});
    stub_nand0 = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 0, 1'b0, 1'b1);
`else
    chk("no_selfcheck.err_tied", {31'b0, err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
